clkgen_multi: RTL



---
 rtl/clkgen_multi.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/clkgen_multi.sv
// Multi-channel runtime-programmable even-ratio clock divider with per-channel rise strobes.
// Optional macro CLKGEN_MULTI_SYNC_EN adds in_sync to phase-align every running channel.
module clkgen_multi #(
    parameter int unsigned MAIN_CLK_HZ = 50_000_000,
    parameter int unsigned DEF_CLK_HZ  = 10_000,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_BITS    = 16,
    parameter logic        CLK_INIT    = 1'b0,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic [NUM_CH-1:0]   in_en,
    input  logic                in_cfg_we,
    input  logic [CH_W-1:0]     in_cfg_ch,
    input  logic [DIV_BITS-1:0] in_cfg_div,
    input  logic [DIV_BITS-1:0] in_cfg_phase,
`ifdef CLKGEN_MULTI_SYNC_EN
    input  logic                in_sync,
`endif
    output logic [NUM_CH-1:0]   out_clk,
    output logic [NUM_CH-1:0]   out_rise,
    output logic [NUM_CH-1:0]   out_pending
);

    localparam logic [DIV_BITS-1:0] DEF_HP = DIV_BITS'(MAIN_CLK_HZ / DEF_CLK_HZ / 2 - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q     [NUM_CH];
    state_e              state_d     [NUM_CH];
    logic [DIV_BITS-1:0] ctr_q       [NUM_CH];
    logic [DIV_BITS-1:0] ctr_d       [NUM_CH];
    logic [DIV_BITS-1:0] hp_q        [NUM_CH];
    logic [DIV_BITS-1:0] hp_d        [NUM_CH];
    logic [DIV_BITS-1:0] phase_q     [NUM_CH];
    logic [DIV_BITS-1:0] phase_d     [NUM_CH];
    logic [DIV_BITS-1:0] hp_nxt_q    [NUM_CH];
    logic [DIV_BITS-1:0] hp_nxt_d    [NUM_CH];
    logic [DIV_BITS-1:0] phase_nxt_q [NUM_CH];
    logic [DIV_BITS-1:0] phase_nxt_d [NUM_CH];
    logic [DIV_BITS-1:0] hp_cm_c     [NUM_CH];
    logic [DIV_BITS-1:0] phase_cm_c  [NUM_CH];
    logic [NUM_CH-1:0]   clk_q;
    logic [NUM_CH-1:0]   clk_d;
    logic [NUM_CH-1:0]   rise_q;
    logic [NUM_CH-1:0]   rise_d;
    logic [NUM_CH-1:0]   pend_q;
    logic [NUM_CH-1:0]   pend_d;
    logic [NUM_CH-1:0]   wr_sel_c;

    // Counter start point: phase clamped to the half period.
    function automatic logic [DIV_BITS-1:0] start_val(input logic [DIV_BITS-1:0] ph,
                                                      input logic [DIV_BITS-1:0] hp);
        return (ph < hp) ? ph : hp;
    endfunction

    // Write decode; out-of-range channel numbers match nothing.
    always_comb begin
        wr_sel_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_cfg_we && (in_cfg_ch == CH_W'(i))) begin
                wr_sel_c[i] = 1'b1;
            end
        end
    end

    // Settings each channel ends up with if its pending values are committed now.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hp_cm_c[i]    = pend_q[i] ? hp_nxt_q[i]    : hp_q[i];
            phase_cm_c[i] = pend_q[i] ? phase_nxt_q[i] : phase_q[i];
        end
    end

    // Per-channel next state.
    always_comb begin
        clk_d  = clk_q;
        pend_d = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]     = state_q[i];
            ctr_d[i]       = ctr_q[i];
            hp_d[i]        = hp_q[i];
            phase_d[i]     = phase_q[i];
            hp_nxt_d[i]    = hp_nxt_q[i];
            phase_nxt_d[i] = phase_nxt_q[i];

            if (state_q[i] == ST_IDLE) begin
                if (!in_en[i]) begin
                    clk_d[i] = CLK_INIT;
                    if (wr_sel_c[i]) begin
                        hp_d[i]    = in_cfg_div;
                        phase_d[i] = in_cfg_phase;
                        ctr_d[i]   = start_val(in_cfg_phase, in_cfg_div);
                    end else begin
                        ctr_d[i]   = start_val(phase_q[i], hp_q[i]);
                    end
                end else begin
                    // Entry cycle already counts from the clamped phase.
                    state_d[i] = ST_RUN;
                    if (start_val(phase_q[i], hp_q[i]) == hp_q[i]) begin
                        ctr_d[i] = '0;
                        clk_d[i] = ~clk_q[i];
                    end else begin
                        ctr_d[i] = start_val(phase_q[i], hp_q[i]) + 1'b1;
                    end
                    if (wr_sel_c[i]) begin
                        hp_nxt_d[i]    = in_cfg_div;
                        phase_nxt_d[i] = in_cfg_phase;
                        pend_d[i]      = 1'b1;
                    end
                end
            end else if (!in_en[i]) begin
                state_d[i] = ST_IDLE;
                clk_d[i]   = CLK_INIT;
                pend_d[i]  = 1'b0;
                if (wr_sel_c[i]) begin
                    hp_d[i]    = in_cfg_div;
                    phase_d[i] = in_cfg_phase;
                    ctr_d[i]   = start_val(in_cfg_phase, in_cfg_div);
                end else begin
                    hp_d[i]    = hp_cm_c[i];
                    phase_d[i] = phase_cm_c[i];
                    ctr_d[i]   = start_val(phase_cm_c[i], hp_cm_c[i]);
                end
            end
`ifdef CLKGEN_MULTI_SYNC_EN
            else if (in_sync) begin
                clk_d[i]   = CLK_INIT;
                hp_d[i]    = hp_cm_c[i];
                phase_d[i] = phase_cm_c[i];
                ctr_d[i]   = start_val(phase_cm_c[i], hp_cm_c[i]);
                pend_d[i]  = 1'b0;
                if (wr_sel_c[i]) begin
                    hp_nxt_d[i]    = in_cfg_div;
                    phase_nxt_d[i] = in_cfg_phase;
                    pend_d[i]      = 1'b1;
                end
            end
`endif
            else begin
                if (ctr_q[i] == hp_q[i]) begin
                    ctr_d[i] = '0;
                    clk_d[i] = ~clk_q[i];
                    // Toggle back to idle level closes a full period.
                    if (clk_q[i] != CLK_INIT) begin
                        hp_d[i]    = hp_cm_c[i];
                        phase_d[i] = phase_cm_c[i];
                        pend_d[i]  = 1'b0;
                    end
                end else begin
                    ctr_d[i] = ctr_q[i] + 1'b1;
                end
                if (wr_sel_c[i]) begin
                    hp_nxt_d[i]    = in_cfg_div;
                    phase_nxt_d[i] = in_cfg_phase;
                    pend_d[i]      = 1'b1;
                end
            end
        end
    end

    // Strobe marks the cycle the output leaves its idle level.
    always_comb begin
        rise_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rise_d[i] = (clk_d[i] != CLK_INIT) && (clk_q[i] == CLK_INIT);
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            clk_q  <= {NUM_CH{CLK_INIT}};
            rise_q <= '0;
            pend_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]     <= ST_IDLE;
                ctr_q[i]       <= '0;
                hp_q[i]        <= DEF_HP;
                phase_q[i]     <= '0;
                hp_nxt_q[i]    <= DEF_HP;
                phase_nxt_q[i] <= '0;
            end
        end else begin
            clk_q  <= clk_d;
            rise_q <= rise_d;
            pend_q <= pend_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]     <= state_d[i];
                ctr_q[i]       <= ctr_d[i];
                hp_q[i]        <= hp_d[i];
                phase_q[i]     <= phase_d[i];
                hp_nxt_q[i]    <= hp_nxt_d[i];
                phase_nxt_q[i] <= phase_nxt_d[i];
            end
        end
    end

    assign out_clk     = clk_q;
    assign out_rise    = rise_q;
    assign out_pending = pend_q;

endmodule
